// File: rtl/cpu_pkg.sv
// Shared encodings for the ARM-subset CPU: FSM states, ALU op codes, condition
// codes, opcode classes and the data-processing cmd decoder.
package cpu_pkg;

    typedef enum logic [3:0] {
        S_FETCH,
        S_DECODE,
        S_EXEC,
        S_ALUWB,
        S_MEMADR,
        S_MEMRD,
        S_MEMWB,
        S_MEMWR,
        S_BRANCH
    } state_t;

    localparam logic [3:0] ALU_ADD = 4'b0000;
    localparam logic [3:0] ALU_SUB = 4'b0001;
    localparam logic [3:0] ALU_AND = 4'b0010;
    localparam logic [3:0] ALU_ORR = 4'b0011;
    localparam logic [3:0] ALU_LSL = 4'b0100;
    localparam logic [3:0] ALU_LSR = 4'b0101;

    localparam logic [3:0] COND_EQ = 4'b0000;
    localparam logic [3:0] COND_NE = 4'b0001;
    localparam logic [3:0] COND_CS = 4'b0010;
    localparam logic [3:0] COND_CC = 4'b0011;
    localparam logic [3:0] COND_MI = 4'b0100;
    localparam logic [3:0] COND_PL = 4'b0101;
    localparam logic [3:0] COND_VS = 4'b0110;
    localparam logic [3:0] COND_VC = 4'b0111;
    localparam logic [3:0] COND_HI = 4'b1000;
    localparam logic [3:0] COND_LS = 4'b1001;
    localparam logic [3:0] COND_GE = 4'b1010;
    localparam logic [3:0] COND_LT = 4'b1011;
    localparam logic [3:0] COND_GT = 4'b1100;
    localparam logic [3:0] COND_LE = 4'b1101;
    localparam logic [3:0] COND_AL = 4'b1110;
    localparam logic [3:0] COND_NV = 4'b1111;

    localparam logic [1:0] OP_DP  = 2'b00;
    localparam logic [1:0] OP_MEM = 2'b01;
    localparam logic [1:0] OP_BR  = 2'b10;

    localparam logic [3:0] CMD_AND = 4'b0000;
    localparam logic [3:0] CMD_SUB = 4'b0010;
    localparam logic [3:0] CMD_ADD = 4'b0100;
    localparam logic [3:0] CMD_ORR = 4'b1100;
    localparam logic [3:0] CMD_LSL = 4'b1101;
    localparam logic [3:0] CMD_LSR = 4'b1110;

    // Returns {legal, alu_op}; unsupported cmds come back with legal=0.
    function automatic logic [4:0] cmd_decode(input logic [3:0] cmd);
        logic [4:0] res;
        case (cmd)
            CMD_ADD: res = {1'b1, ALU_ADD};
            CMD_SUB: res = {1'b1, ALU_SUB};
            CMD_AND: res = {1'b1, ALU_AND};
            CMD_ORR: res = {1'b1, ALU_ORR};
            CMD_LSL: res = {1'b1, ALU_LSL};
            CMD_LSR: res = {1'b1, ALU_LSR};
            default: res = {1'b0, ALU_ADD};
        endcase
        return res;
    endfunction

endpackage

// File: rtl/cond_check.sv
// Combinational ARM condition evaluation against an NZCV flag word.
module cond_check
    import cpu_pkg::*;
(
    input  logic [3:0] cond,
    input  logic [3:0] nzcv,
    output logic       pass
);

    logic flag_n;
    logic flag_z;
    logic flag_c;
    logic flag_v;

    assign flag_n = nzcv[3];
    assign flag_z = nzcv[2];
    assign flag_c = nzcv[1];
    assign flag_v = nzcv[0];

    always_comb begin
        pass = 1'b0;
        case (cond)
            COND_EQ: pass = flag_z;
            COND_NE: pass = !flag_z;
            COND_CS: pass = flag_c;
            COND_CC: pass = !flag_c;
            COND_MI: pass = flag_n;
            COND_PL: pass = !flag_n;
            COND_VS: pass = flag_v;
            COND_VC: pass = !flag_v;
            COND_HI: pass = flag_c && !flag_z;
            COND_LS: pass = !flag_c || flag_z;
            COND_GE: pass = (flag_n == flag_v);
            COND_LT: pass = (flag_n != flag_v);
            COND_GT: pass = !flag_z && (flag_n == flag_v);
            COND_LE: pass = flag_z || (flag_n != flag_v);
            COND_AL: pass = 1'b1;
            default: pass = 1'b0;
        endcase
    end

endmodule

// File: rtl/multicycle_controller.sv
// Multi-cycle sequencer: instruction decode, NZCV flag register, condition
// gating and the FSM driving every datapath strobe, stalling on mem_ready.
module multicycle_controller
    import cpu_pkg::*;
(
    input  logic       clk,
    input  logic       rst,
    input  logic [3:0] cond,
    input  logic [1:0] op,
    input  logic [5:0] funct,
    input  logic [3:0] rd,
    input  logic [3:0] alu_flags,
    input  logic       mem_ready,
    output logic       ir_write,
    output logic       pc_write,
    output logic       adr_src,
    output logic       mem_read,
    output logic       mem_write,
    output logic       reg_write,
    output logic [1:0] result_src,
    output logic       alu_src_a,
    output logic [1:0] alu_src_b,
    output logic [3:0] alu_control,
    output logic       instr_done,
    output logic       illegal
);

    state_t     state_reg;
    state_t     state_next;
    logic [3:0] nzcv_reg;
    logic [3:0] nzcv_next;
    logic       run_reg;

    logic       cond_pass;
    logic [4:0] cmd_info;
    logic       cmd_legal;
    logic [3:0] cmd_alu;
    logic       is_imm;
    logic       s_bit;
    logic       rd_is_pc;

    assign cmd_info  = cmd_decode(funct[4:1]);
    assign cmd_legal = cmd_info[4];
    assign cmd_alu   = cmd_info[3:0];
    assign is_imm    = funct[5];
    assign s_bit     = funct[0];
    assign rd_is_pc  = (rd == 4'b1111);

    cond_check u_cond_check (
        .cond (cond),
        .nzcv (nzcv_reg),
        .pass (cond_pass)
    );

    // run_reg keeps every strobe low until the first edge after reset release.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_reg <= S_FETCH;
            nzcv_reg  <= 4'b0000;
            run_reg   <= 1'b0;
        end else begin
            state_reg <= state_next;
            nzcv_reg  <= nzcv_next;
            run_reg   <= 1'b1;
        end
    end

    always_comb begin
        state_next  = state_reg;
        nzcv_next   = nzcv_reg;
        ir_write    = 1'b0;
        pc_write    = 1'b0;
        adr_src     = 1'b0;
        mem_read    = 1'b0;
        mem_write   = 1'b0;
        reg_write   = 1'b0;
        result_src  = 2'b00;
        alu_src_a   = 1'b0;
        alu_src_b   = 2'b00;
        alu_control = ALU_ADD;
        instr_done  = 1'b0;
        illegal     = 1'b0;

        if (run_reg) begin
            case (state_reg)
                S_FETCH: begin
                    mem_read  = 1'b1;
                    alu_src_a = 1'b1;
                    alu_src_b = 2'b10;
                    if (mem_ready) begin
                        ir_write   = 1'b1;
                        pc_write   = 1'b1;
                        result_src = 2'b10;
                        state_next = S_DECODE;
                    end
                end
                S_DECODE: begin
                    alu_src_a = 1'b1;
                    alu_src_b = 2'b10;
                    if (!cond_pass) begin
                        instr_done = 1'b1;
                        state_next = S_FETCH;
                    end else if (op == OP_DP && cmd_legal) begin
                        state_next = S_EXEC;
                    end else if (op == OP_MEM) begin
                        state_next = S_MEMADR;
                    end else if (op == OP_BR) begin
                        state_next = S_BRANCH;
                    end else begin
                        illegal    = 1'b1;
                        instr_done = 1'b1;
                        state_next = S_FETCH;
                    end
                end
                S_EXEC: begin
                    alu_src_b   = is_imm ? 2'b01 : 2'b00;
                    alu_control = cmd_alu;
                    state_next  = S_ALUWB;
                end
                S_ALUWB: begin
                    reg_write  = 1'b1;
                    pc_write   = rd_is_pc;
                    instr_done = 1'b1;
                    if (s_bit) begin
                        nzcv_next = alu_flags;
                    end
                    state_next = S_FETCH;
                end
                S_MEMADR: begin
                    alu_src_b  = 2'b01;
                    state_next = s_bit ? S_MEMRD : S_MEMWR;
                end
                S_MEMRD: begin
                    mem_read = 1'b1;
                    adr_src  = 1'b1;
                    if (mem_ready) begin
                        state_next = S_MEMWB;
                    end
                end
                S_MEMWB: begin
                    reg_write  = 1'b1;
                    result_src = 2'b01;
                    pc_write   = rd_is_pc;
                    instr_done = 1'b1;
                    state_next = S_FETCH;
                end
                S_MEMWR: begin
                    mem_write = 1'b1;
                    adr_src   = 1'b1;
                    if (mem_ready) begin
                        instr_done = 1'b1;
                        state_next = S_FETCH;
                    end
                end
                S_BRANCH: begin
                    alu_src_b  = 2'b01;
                    result_src = 2'b10;
                    pc_write   = 1'b1;
                    instr_done = 1'b1;
                    state_next = S_FETCH;
                end
                default: begin
                    state_next = S_FETCH;
                end
            endcase
        end
    end

endmodule
